wb_regfile_scoreboard: RTL and testbench

Consumer end of the EXE/WB pipeline register. It takes the registered writeback triple (ALU result, rd, regwrite) and commits it to the architectural register file. It serves the two ID-stage read ports with write-through bypass. A per-register pending-write scoreboard raises a stall toward ID while a source register still has an uncommitted write in flight.

---
 rtl/wb_regfile_scoreboard.sv | 57 +++++
 tb/tb_wb_regfile_scoreboard.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard: writeback register file with bypassed read ports and per-register pending-write scoreboard
module wb_regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic            id_issue,
  input  logic [4:0]      id_rd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            pend_any
);
  localparam logic [PEND_W-1:0] CMAX = '1;
  localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);
  logic [XLEN-1:0]   regs [0:31];
  logic [PEND_W-1:0] cnt  [0:31];
  logic dec, acc, haz1, haz2, ovf;
  assign dec      = wb_regwrite && wb_rd != 5'd0;
  assign haz1     = id_rs1_used && id_rs1 != 5'd0 &&
                    (cnt[id_rs1] > ONE || (cnt[id_rs1] == ONE && !(dec && wb_rd == id_rs1)));
  assign haz2     = id_rs2_used && id_rs2 != 5'd0 &&
                    (cnt[id_rs2] > ONE || (cnt[id_rs2] == ONE && !(dec && wb_rd == id_rs2)));
  assign ovf      = id_issue && id_rd != 5'd0 && cnt[id_rd] == CMAX && !(dec && wb_rd == id_rd);
  assign stall    = haz1 | haz2 | ovf;
  assign acc      = id_issue && !stall && id_rd != 5'd0;
  assign rs1_data = id_rs1 == 5'd0 ? '0 : (wb_regwrite && wb_rd == id_rs1) ? wb_data : regs[id_rs1];
  assign rs2_data = id_rs2 == 5'd0 ? '0 : (wb_regwrite && wb_rd == id_rs2) ? wb_data : regs[id_rs2];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (dec)
      regs[wb_rd] <= wb_data;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    else
      for (int i = 1; i < 32; i++) begin
        if (acc && id_rd == 5'(i) && !(dec && wb_rd == 5'(i)))
          cnt[i] <= cnt[i] + ONE;
        else if (dec && wb_rd == 5'(i) && !(acc && id_rd == 5'(i)) && cnt[i] != '0)
          cnt[i] <= cnt[i] - ONE;
      end
  always_comb begin
    pend_any = 1'b0;
    for (int i = 1; i < 32; i++) pend_any = pend_any | (cnt[i] != '0);
  end
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) dec |-> cnt[wb_rd] != '0);
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// tb_wb_regfile_scoreboard: directed and randomized checks against a behavioural register/scoreboard model
module tb_wb_regfile_scoreboard;
  localparam int MAXP = 3;
  logic        clk = 0, rst = 1;
  logic        wb_regwrite = 0, id_rs1_used = 0, id_rs2_used = 0, id_issue = 0;
  logic [4:0]  wb_rd = 0, id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [31:0] wb_data = 0, rs1_data, rs2_data;
  logic        stall, pend_any;
  int          checks = 0, errors = 0;
  int          mcnt [32];
  logic [31:0] mreg [32];
  logic [31:0] o_rs1, o_rs2;
  logic        o_stall, o_pend;

  wb_regfile_scoreboard #(.XLEN(32), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_issue(id_issue), .id_rd(id_rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_regwrite && wb_rd == r) return wb_data;
    return mreg[r];
  endfunction

  // outstanding writes to r once this cycle's commit (if any) is accounted for
  function automatic int left(input logic [4:0] r);
    return mcnt[r] - ((wb_regwrite && wb_rd != 0 && wb_rd == r) ? 1 : 0);
  endfunction

  function automatic logic mstall();
    logic h1, h2, ov;
    h1 = id_rs1_used && id_rs1 != 0 && left(id_rs1) > 0;
    h2 = id_rs2_used && id_rs2 != 0 && left(id_rs2) > 0;
    ov = id_issue && id_rd != 0 && left(id_rd) >= MAXP;
    return h1 || h2 || ov;
  endfunction

  function automatic logic mpend();
    for (int r = 1; r < 32; r++) if (mcnt[r] > 0) return 1;
    return 0;
  endfunction

  task automatic mclear();
    for (int r = 0; r < 32; r++) begin mcnt[r] = 0; mreg[r] = 0; end
  endtask

  task automatic step(input logic wr, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                      input logic iss, input logic [4:0] ird);
    logic es;
    @(negedge clk);
    wb_regwrite = wr; wb_rd = wrd; wb_data = wd;
    id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2; id_issue = iss; id_rd = ird;
    #1;
    es = mstall();
    o_rs1 = rs1_data; o_rs2 = rs2_data; o_stall = stall; o_pend = pend_any;
    check("rs1_data", rs1_data, mread(id_rs1));
    check("rs2_data", rs2_data, mread(id_rs2));
    check("stall", 32'(stall), 32'(es));
    check("pend_any", 32'(pend_any), 32'(mpend()));
    @(posedge clk);
    if (wr && wrd != 0) begin mreg[wrd] = wd; mcnt[wrd]--; end
    if (iss && !es && ird != 0) mcnt[ird]++;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, r1, 0, r2, 0, 0, 0);
  endtask

  task automatic issue(input logic [4:0] rd);
    step(0, 0, 0, 0, 0, 0, 0, 1, rd);
  endtask

  initial begin
    logic [4:0] q [$];
    logic wr, iss;
    logic [4:0] wrd, ird;
    mclear();
    #1;
    check("reset_rs1", rs1_data, 0);
    check("reset_stall", 32'(stall), 0);
    check("reset_pend", 32'(pend_any), 0);
    @(negedge clk); rst = 0;
    idle(5, 0);
    check("x5_init", o_rs1, 0);
    check("x0_init", o_rs2, 0);
    issue(5);
    step(1, 5, 32'hDEADBEEF, 5, 1, 0, 0, 0, 0);
    check("bypass_x5", o_rs1, 32'hDEADBEEF);
    check("bypass_nostall", 32'(o_stall), 0);
    idle(5, 0);
    check("array_x5", o_rs1, 32'hDEADBEEF);
    step(1, 0, 32'h1234, 0, 1, 0, 1, 0, 0);
    idle(0, 5);
    check("x0_ignored", o_rs1, 0);
    check("x5_kept", o_rs2, 32'hDEADBEEF);
    issue(7);
    step(0, 0, 0, 7, 1, 0, 0, 0, 0);
    check("raw_stall", 32'(o_stall), 1);
    check("raw_pend", 32'(o_pend), 1);
    step(1, 7, 32'h55, 7, 1, 0, 0, 0, 0);
    check("commit_nostall", 32'(o_stall), 0);
    check("commit_data", o_rs1, 32'h55);
    repeat (3) issue(9);
    issue(9);
    check("ovf_stall", 32'(o_stall), 1);
    step(1, 9, 32'h99, 0, 0, 0, 0, 1, 9);
    check("ovf_cancel", 32'(o_stall), 0);
    issue(9);
    check("cnt9_still3", 32'(o_stall), 1);
    repeat (3) step(1, 9, $urandom, 9, 1, 0, 0, 0, 0);
    step(0, 0, 0, 9, 1, 0, 0, 0, 0);
    check("x9_drained", 32'(o_stall), 0);
    issue(3);
    step(1, 3, 32'h33, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 3, 1, 0, 0);
    check("rs2_3_stall", 32'(o_stall), 1);
    step(1, 3, 32'h34, 0, 0, 3, 1, 0, 0);
    check("rs2_3_release", 32'(o_stall), 0);
    check("rs2_3_data", o_rs2, 32'h34);
    repeat (3) issue(4);
    step(1, 4, 32'hABCD, 0, 0, 0, 0, 0, 0);
    idle(4, 0);
    check("x4_before_rst", o_rs1, 32'hABCD);
    rst = 1; #1;
    mclear();
    check("rst_x4", rs1_data, 0);
    check("rst_pend", 32'(pend_any), 0);
    check("rst_stall", 32'(stall), 0);
    @(negedge clk); rst = 0;
    for (int n = 0; n < 3000; n++) begin
      q.delete();
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0) q.push_back(5'(r));
      wr = 0; wrd = 5'($urandom_range(0, 31));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin wr = 1; wrd = q[$urandom_range(0, q.size() - 1)]; end
      else if ($urandom_range(0, 7) == 0) begin wr = 1; wrd = 0; end
      iss = $urandom_range(0, 2) != 0;
      ird = 5'($urandom_range(0, 6));
      step(wr, wrd, $urandom, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), iss, ird);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
